// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: one operand bit per cycle, LSB first, with valid/ready handshakes.
// Define ALU_SERIAL_ABORT_EN to add an abort input that cancels an operation in RUN.
module alu_bit_serial_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ALU_SERIAL_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] work;
   logic [3:0]       ctrl_q;
   logic             carry;
   logic             op_a, op_b, sum, cout, bit_res, set, last, abort_req;
   logic [WIDTH-1:0] shifted, final_res;

   // Operands shift right so the active bit is always at index 0; result bits enter from the top.
   always_comb begin
      op_a    = a_sh[0] ^ ctrl_q[3];
      op_b    = b_sh[0] ^ ctrl_q[2];
      sum     = op_a ^ op_b ^ carry;
      cout    = (op_a & op_b) | (carry & (op_a ^ op_b));
      bit_res = 1'b0;
      case (ctrl_q[1:0])
         2'b00:   bit_res = op_a & op_b;
         2'b01:   bit_res = op_a | op_b;
         2'b10:   bit_res = sum;
         default: bit_res = 1'b0;
      endcase
      set       = (carry ^ cout) ^ sum;
      last      = (cnt == CNT_W'(WIDTH - 1));
      shifted   = {bit_res, work};
      final_res = shifted;
      if (ctrl_q[1:0] == 2'b11) begin
         final_res[0] = set;
      end
`ifdef ALU_SERIAL_ABORT_EN
      abort_req = abort;
`else
      abort_req = 1'b0;
`endif
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (abort_req)  state_nxt = IDLE;
            else if (last)  state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         ctrl_q    <= '0;
         work      <= '0;
         result    <= '0;
         zero      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  ctrl_q <= alu_ctrl;
                  carry  <= alu_ctrl[2];
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (abort_req) begin
                  cnt <= '0;
               end else begin
                  a_sh  <= a_sh >> 1;
                  b_sh  <= b_sh >> 1;
                  carry <= cout;
                  work  <= shifted[WIDTH-1:1];
                  if (last) begin
                     result    <= final_res;
                     zero      <= (final_res == '0);
                     carry_out <= cout;
                     overflow  <= carry ^ cout;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed self-checking bench for alu_bit_serial_seq (default WIDTH=32).
module tb_alu_bit_serial_seq;
   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, out_valid, out_ready;
   logic         zero, carry_out, overflow;
   logic [W-1:0] a, b, result;
   logic [3:0]   alu_ctrl;
`ifdef ALU_SERIAL_ABORT_EN
   logic         abort;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   c;
      logic [W-1:0] r;
      logic         z;
      logic         co;
      logic         v;
   } vec_t;

   always #5 clk = ~clk;

   alu_bit_serial_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .alu_ctrl(alu_ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
`ifdef ALU_SERIAL_ABORT_EN
      .abort(abort),
`endif
      .result(result),
      .zero(zero),
      .carry_out(carry_out),
      .overflow(overflow)
   );

   // Presents a request for one edge; returns whether in_ready was high at that edge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [3:0] tc, output bit acc);
      a = ta;
      b = tb;
      alu_ctrl = tc;
      in_valid = 1'b1;
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Edges until out_valid is seen, or -1 after 100 edges.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      n_checks++;
      if (result !== '0 || zero !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: result=%h z=%b c=%b v=%b expected all 0",
                  result, zero, carry_out, overflow);
      end
   endtask

   task automatic test_ops();
      vec_t vecs [11];
      int   lat;
      bit   acc;
      vecs = '{
         '{32'h00000005, 32'h00000003, 4'b0010, 32'h00000008, 1'b0, 1'b0, 1'b0},
         '{32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
         '{32'h00001234, 32'h00001234, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0},
         '{32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b1, 1'b0},
         '{32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b1},
         '{32'h00000055, 32'h00000055, 4'b0111, 32'h00000000, 1'b1, 1'b1, 1'b0},
         '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1},
         '{32'h0000FFFF, 32'h00FF0000, 4'b1100, 32'hFF000000, 1'b0, 1'b1, 1'b0},
         '{32'hF0F00000, 32'h00000F0F, 4'b0001, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0},
         '{32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0},
         '{32'h00000002, 32'h00000005, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0}
      };
      for (int i = 0; i < 11; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].c, acc);
         n_checks++;
         if (!acc) begin
            n_fail++;
            $display("FAIL op%0d_accept: in_ready=0 expected 1", i);
         end
         wait_done(lat);
         n_checks++;
         if (lat != 32) begin
            n_fail++;
            $display("FAIL op%0d_latency: got %0d edges expected 32", i, lat);
         end
         n_checks++;
         if (result !== vecs[i].r || zero !== vecs[i].z) begin
            n_fail++;
            $display("FAIL op%0d_result: got %h z=%b expected %h z=%b",
                     i, result, zero, vecs[i].r, vecs[i].z);
         end
         n_checks++;
         if (carry_out !== vecs[i].co || overflow !== vecs[i].v) begin
            n_fail++;
            $display("FAIL op%0d_flags: got c=%b v=%b expected c=%b v=%b",
                     i, carry_out, overflow, vecs[i].co, vecs[i].v);
         end
         release_out();
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== vecs[i].r) begin
            n_fail++;
            $display("FAIL op%0d_after_hs: out_valid=%b in_ready=%b result=%h expected 0 1 %h",
                     i, out_valid, in_ready, result, vecs[i].r);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      bit acc;
      start_op(32'h5, 32'h3, 4'b0010, acc);
      wait_done(lat);
      n_checks++;
      if (lat != 32) begin
         n_fail++;
         $display("FAIL hold_latency: got %0d expected 32", lat);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || result !== 32'h8 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: out_valid=%b result=%h in_ready=%b expected 1 00000008 0",
                     i, out_valid, result, in_ready);
         end
      end
      release_out();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_busy_ignored();
      int lat;
      bit acc;
      start_op(32'h10, 32'h20, 4'b0010, acc);
      for (int i = 0; i < 5; i++) begin
         a = 32'hFFFFFFFF;
         b = 32'hFFFFFFFF;
         alu_ctrl = 4'b0110;
         in_valid = 1'b1;
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready%0d: in_ready=%b expected 0", i, in_ready);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_done(lat);
      n_checks++;
      if (lat != 27) begin
         n_fail++;
         $display("FAIL busy_latency: got %0d expected 27", lat);
      end
      n_checks++;
      if (result !== 32'h30) begin
         n_fail++;
         $display("FAIL busy_result: got %h expected 00000030", result);
      end
      release_out();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_not_queued: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int  lat;
      bit  acc;
      bit  seen;
      start_op(32'h7FFFFFFF, 32'h1, 4'b0010, acc);
      wait_done(lat);
      release_out();
      start_op(32'h5, 32'h3, 4'b0010, acc);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      n_checks++;
      if (result !== '0 || zero !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_outs: result=%h z=%b c=%b v=%b expected all 0",
                  result, zero, carry_out, overflow);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL midreset_no_valid: out_valid seen=1 expected 0");
      end
   endtask

`ifdef ALU_SERIAL_ABORT_EN
   task automatic test_abort();
      int lat;
      bit acc;
      bit seen;
      start_op(32'h1, 32'h2, 4'b0010, acc);
      wait_done(lat);
      release_out();
      start_op(32'h3, 32'h5, 4'b0110, acc);
      repeat (5) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      n_checks++;
      if (result !== 32'h3) begin
         n_fail++;
         $display("FAIL abort_result_kept: got %h expected 00000003", result);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL abort_no_valid: out_valid seen=1 expected 0");
      end
      start_op(32'h1, 32'h1, 4'b0010, acc);
      wait_done(lat);
      n_checks++;
      if (lat != 32 || result !== 32'h2) begin
         n_fail++;
         $display("FAIL abort_followup: lat=%0d result=%h expected 32 00000002", lat, result);
      end
      release_out();
   endtask
`endif

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      alu_ctrl = '0;
`ifdef ALU_SERIAL_ABORT_EN
      abort = 1'b0;
`endif
      @(posedge clk);
      #1;
      test_reset();
      test_ops();
      test_hold();
      test_busy_ignored();
      test_reset_mid();
`ifdef ALU_SERIAL_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_bit_serial_seq.md
Name: alu_bit_serial_seq

Overview:
Sequencer that drives a single 1-bit ALU slice over time rather than across a ripple chain. One operand bit is processed per cycle, LSB first. The carry is held in a flop between cycles, and Set/Overflow are resolved at the MSB. For SLT, bit 0 of the result is rewritten after the last bit is processed. Intended as the area-minimal ALU option for the multicycle datapath, with a valid/ready handshake to the control unit.

Parameters:
WIDTH, 32, operand/result width in bits; minimum 2.
CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
alu_ctrl  input  4  {Ainvert, Binvert, Operation[1:0]}; 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  final result.
zero  output  1  high when result equals 0.
carry_out  output  1  carry out of the MSB.
overflow  output  1  signed overflow at the MSB (CarryIn xor CarryOut of the MSB).

Behaviour:
- Single clock domain: clk. Synchronous active-high reset. Every state change happens on the rising edge of clk.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry_out=0, overflow=0, counter=0, carry flop=0. Reset mid-operation abandons the operation; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_valid & in_ready on an edge: capture a, b, alu_ctrl into shadow registers; carry flop <= Binvert; counter <= 0; go to RUN.
  - Input changes after capture are ignored.
- RUN, one bit k = counter per cycle:
  - Operands: opA = a[k]^Ainvert, opB = b[k]^Binvert.
  - Per-bit result by Operation: 00 -> opA&opB; 01 -> opA|opB; 10 -> full-adder sum of opA, opB, carry; 11 -> Less, where Less=0 for every bit.
  - result[k] <= per-bit result.
  - carry <= full-adder carry-out. The adder runs for every operation.
  - When k = WIDTH-1:
    - overflow <= carry_in_msb ^ carry_out_msb
    - carry_out <= carry_out_msb
    - set = overflow ^ sum_msb
    - go to DONE
  - Otherwise counter <= k+1.
- Entering DONE:
  - If Operation = 11, result[0] <= set; all other result bits stay 0.
  - zero is evaluated on the final result, including the SLT fixup.
  - out_valid=1.
- DONE:
  - result, zero, carry_out, overflow and out_valid hold until out_valid & out_ready on an edge, then go to IDLE.
  - After the handshake, out_valid=0 the next cycle. result/flags hold their last values.
- Latency: request accepted on edge E; out_valid is high after edge E+WIDTH (32 for the default).
- Throughput: one op per WIDTH+2 cycles when out_ready is held high. There is no overlap: in_ready=0 from acceptance until return to IDLE.
- in_valid while busy: ignored, not queued.
- overflow/carry_out are reported for all ops and are meaningful only for ADD/SUB/SLT.
- Undefined alu_ctrl codes execute per the field bits with no error.

Optional Feature:
ALU_SERIAL_ABORT_EN:
- When defined, adds input port abort (1 bit).
- abort high on an edge while in RUN: go to IDLE, counter=0, out_valid stays 0. result/flags keep their prior values.
- abort is ignored in IDLE and DONE.
- When undefined, the port does not exist and RUN always completes.

Test Plan:
- ADD a=5, b=3, ctrl=0010 -> result=0x00000008, zero=0, overflow=0; out_valid exactly 32 edges after acceptance.
- SUB a=3, b=5, ctrl=0110 -> result=0xFFFFFFFE, carry_out=0, overflow=0; SUB a=b=0x1234 -> result=0, zero=1, carry_out=1.
- SLT cases, ctrl=0111:
  - a=0xFFFFFFFF, b=1 -> result=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> overflow=1, result=0.
  - a=b -> result=0, zero=1.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1; NOR a=0x0000FFFF, b=0x00FF0000, ctrl=1100 -> result=0xFF000000.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, out_valid stays 1.
  - in_valid pulses during RUN -> ignored.
  - Reset asserted at bit 10 -> next cycle IDLE, all outputs 0, no out_valid.
- With ALU_SERIAL_ABORT_EN: abort at bit 5 -> IDLE next cycle, in_ready=1, no out_valid; a following ADD 1+1 -> result=2.
